nv_nvdla_reset_seq: RTL and testbench

NV_NVDLA_RESET_SEQ -- requirements
Module: nv_nvdla_reset_seq

---
 rtl/nv_nvdla_reset_seq_pkg.sv | 33 +++
 rtl/nv_nvdla_reset_seq_cnt.sv | 34 +++
 rtl/nv_nvdla_reset_seq.sv | 177 +++++++++++++++++
 tb/tb_nv_nvdla_reset_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_reset_seq_pkg.sv
// Shared definitions for the NVDLA reset sequencer: FSM state encoding,
// default parameter values and a small sizing helper.
package nv_nvdla_reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_PART    = 4;
  localparam int DEF_HOLD_CYC    = 16;
  localparam int DEF_GAP_CYC     = 4;
  localparam int DEF_TIMEOUT_CYC = 256;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/nv_nvdla_reset_seq_cnt.sv
// Loadable down-counter with zero flag, shared by the DRAIN, HOLD and RELEASE
// phases of the reset sequencer. Saturates at zero; load has priority over dec.
module nv_nvdla_reset_seq_cnt
  import nv_nvdla_reset_seq_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // count register: reset preset, then load / decrement-to-zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_W'(RST_VAL);
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/nv_nvdla_reset_seq.sv
// NVDLA partition reset sequencer: drain, hold all partition resets, staged release.
// Optional drain timeout enabled by defining NVDLA_RESET_SEQ_TIMEOUT_EN.
module nv_nvdla_reset_seq
  import nv_nvdla_reset_seq_pkg::*;
#(
  parameter int NUM_PART    = DEF_NUM_PART,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                nvdla_clk,
  input  logic                dla_reset,
  input  logic                test_mode,
  input  logic                sw_rst_req,
  output logic                sw_rst_ack,
  input  logic [NUM_PART-1:0] part_idle,
  output logic [NUM_PART-1:0] part_rst,
  output logic                busy,
  output logic                timeout_err
);

`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
  localparam int CNT_MAX = max3(HOLD_CYC, GAP_CYC, TIMEOUT_CYC);
`else
  localparam int CNT_MAX = max3(HOLD_CYC, GAP_CYC, 1);
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int IDX_W = $clog2(NUM_PART);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PART - 1);

  seq_state_e          state_r, state_s;
  logic [IDX_W-1:0]    idx_r, idx_s, idx_inc_s;
  logic [NUM_PART-1:0] rst_vec_r, rst_vec_s;
  logic                armed_r, armed_s;
  logic                sw_seq_r, sw_seq_s;
  logic                ack_r, ack_s;
  logic                cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [CNT_W-1:0]    cnt_val_s;
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
  logic                terr_r, terr_s;
`endif

  // The reset preset makes the counter ready to time HOLD straight out of reset.
  nv_nvdla_reset_seq_cnt #(
    .CNT_W  (CNT_W),
    .RST_VAL(HOLD_CYC - 1)
  ) u_cnt (
    .clk     (nvdla_clk),
    .rst     (dla_reset),
    .load    (cnt_load_s),
    .load_val(cnt_val_s),
    .dec     (cnt_dec_s),
    .zero    (cnt_zero_s)
  );

  assign idx_inc_s = idx_r + IDX_W'(1);

  // next-state, release schedule, arming and ack generation
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    rst_vec_s  = rst_vec_r;
    armed_s    = armed_r | ~sw_rst_req;
    sw_seq_s   = sw_seq_r;
    ack_s      = 1'b0;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    cnt_val_s  = '0;
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
    terr_s     = terr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (sw_rst_req && armed_r) begin
          state_s  = ST_DRAIN;
          armed_s  = 1'b0;
          sw_seq_s = 1'b1;
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
          terr_s     = 1'b0;
          cnt_load_s = 1'b1;
          cnt_val_s  = CNT_W'(TIMEOUT_CYC - 1);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (&part_idle) begin
          state_s    = ST_HOLD;
          rst_vec_s  = '1;
          cnt_load_s = 1'b1;
          cnt_val_s  = CNT_W'(HOLD_CYC - 1);
        end
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
        else if (cnt_zero_s) begin
          state_s    = ST_HOLD;
          rst_vec_s  = '1;
          terr_s     = 1'b1;
          cnt_load_s = 1'b1;
          cnt_val_s  = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_dec_s = 1'b1;
        end
`else
        else begin
          state_s = ST_DRAIN;
        end
`endif
      end
      ST_HOLD: begin
        if (cnt_zero_s) begin
          state_s      = ST_RELEASE;
          idx_s        = '0;
          rst_vec_s[0] = 1'b0;
          cnt_load_s   = 1'b1;
          cnt_val_s    = CNT_W'(GAP_CYC - 1);
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_RELEASE: begin
        // The last partition was released on the previous edge.
        if (idx_r == IDX_LAST) begin
          state_s  = ST_IDLE;
          ack_s    = sw_seq_r;
          sw_seq_s = 1'b0;
        end else if (cnt_zero_s) begin
          idx_s                = idx_inc_s;
          rst_vec_s[idx_inc_s] = 1'b0;
          cnt_load_s           = 1'b1;
          cnt_val_s            = CNT_W'(GAP_CYC - 1);
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // sequencer state registers; dla_reset forces a fresh HOLD
  always_ff @(posedge nvdla_clk) begin
    if (dla_reset) begin
      state_r   <= ST_HOLD;
      idx_r     <= '0;
      rst_vec_r <= '1;
      armed_r   <= 1'b0;
      sw_seq_r  <= 1'b0;
      ack_r     <= 1'b0;
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
      terr_r    <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      rst_vec_r <= rst_vec_s;
      armed_r   <= armed_s;
      sw_seq_r  <= sw_seq_s;
      ack_r     <= ack_s;
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
      terr_r    <= terr_s;
`endif
    end
  end

  // DFT bypass drives every partition reset straight from dla_reset.
  assign part_rst   = test_mode ? {NUM_PART{dla_reset}} : rst_vec_r;
  assign busy       = (state_r != ST_IDLE);
  assign sw_rst_ack = ack_r;
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
  assign timeout_err = terr_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_nv_nvdla_reset_seq.sv
// Bench for nv_nvdla_reset_seq: elapsed-time reference model checked every cycle,
// plus directed scenarios with hand-computed edge expectations.
module tb_nv_nvdla_reset_seq;

  localparam int N       = 4;
  localparam int HOLD    = 16;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 256;
  localparam int SEQ_END = HOLD + (N - 1) * GAP + 1;
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         dla_reset, test_mode, sw_rst_req;
  logic [N-1:0] part_idle;
  logic         sw_rst_ack, busy, timeout_err;
  logic [N-1:0] part_rst;

  int n_chk = 0;
  int n_fail = 0;
  int ack_cnt = 0;

  // Reference model: phase 0 idle, 1 drain, 2 reset sequence; t counts edges since HOLD entry.
  int ph = 0;
  int t = 0;
  int dt = 0;
  bit m_sw = 1'b0, m_armed = 1'b0, m_terr = 1'b0, m_ack = 1'b0, valid = 1'b0;

  nv_nvdla_reset_seq #(
    .NUM_PART(N), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .nvdla_clk  (clk),
    .dla_reset  (dla_reset),
    .test_mode  (test_mode),
    .sw_rst_req (sw_rst_req),
    .sw_rst_ack (sw_rst_ack),
    .part_idle  (part_idle),
    .part_rst   (part_rst),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // model advance on each edge, then compare all outputs shortly after it
  always @(posedge clk) begin
    logic [N-1:0] exp_rst;
    bit nxt_armed;
    if (dla_reset) begin
      ph = 2; t = 0; m_sw = 1'b0; m_armed = 1'b0; m_terr = 1'b0; m_ack = 1'b0;
      valid = 1'b1;
    end else begin
      m_ack = 1'b0;
      nxt_armed = m_armed | !sw_rst_req;
      if (ph == 0) begin
        if (sw_rst_req && m_armed) begin
          ph = 1; dt = 0; m_sw = 1'b1; m_terr = 1'b0; nxt_armed = 1'b0;
        end
      end else if (ph == 1) begin
        if (&part_idle) begin
          ph = 2; t = 0;
        end else begin
          dt++;
          if (TO_EN && dt == TIMEOUT) begin
            ph = 2; t = 0; m_terr = 1'b1;
          end
        end
      end else begin
        t++;
        if (t == SEQ_END) begin
          ph = 0; m_ack = m_sw; m_sw = 1'b0;
        end
      end
      m_armed = nxt_armed;
    end
    #1;
    if (valid) begin
      exp_rst = '0;
      if (ph == 2) begin
        for (int i = 0; i < N; i++) exp_rst[i] = (t < HOLD + i * GAP);
      end
      if (test_mode) exp_rst = {N{dla_reset}};
      chk("model_part_rst", 32'(part_rst), 32'(exp_rst));
      chk("model_busy", 32'(busy), 32'(ph != 0));
      chk("model_ack", 32'(sw_rst_ack), 32'(m_ack));
      chk("model_timeout_err", 32'(timeout_err), 32'(m_terr));
      if (sw_rst_ack === 1'b1) ack_cnt++;
    end
  end

  initial begin
    int a0;
    dla_reset = 1'b1; test_mode = 1'b0; sw_rst_req = 1'b0; part_idle = 4'hF;

    // power-on: reset held three edges, then staged release at 16/20/24/28
    step(3);
    chk("rst_part_rst", 32'(part_rst), 32'h0000_000F);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_ack", 32'(sw_rst_ack), 32'h0);
    dla_reset = 1'b0;
    step(15); chk("por_e15", 32'(part_rst), 32'hF);
    step(1);  chk("por_e16", 32'(part_rst), 32'hE);
    step(3);  chk("por_e19", 32'(part_rst), 32'hE);
    step(1);  chk("por_e20", 32'(part_rst), 32'hC);
    step(4);  chk("por_e24", 32'(part_rst), 32'h8);
    step(4);  chk("por_e28", 32'(part_rst), 32'h0);
    chk("por_busy_e28", 32'(busy), 32'h1);
    step(1);  chk("por_busy_e29", 32'(busy), 32'h0);
    chk("por_no_ack", 32'(ack_cnt), 32'd0);

    // software pulse with all partitions idle
    a0 = ack_cnt;
    sw_rst_req = 1'b1; step(1);
    sw_rst_req = 1'b0;
    chk("sw_drain_busy", 32'(busy), 32'h1);
    chk("sw_drain_rst", 32'(part_rst), 32'h0);
    step(1);  chk("sw_hold_t0", 32'(part_rst), 32'hF);
    part_idle = 4'h3;
    step(15); chk("sw_hold_t15", 32'(part_rst), 32'hF);
    step(1);  chk("sw_rel_t16", 32'(part_rst), 32'hE);
    part_idle = 4'hF;
    step(13); chk("sw_done_busy", 32'(busy), 32'h0);
    chk("sw_one_ack", 32'(ack_cnt - a0), 32'd1);

    // request held high for 100 cycles: one sequence only
    a0 = ack_cnt;
    sw_rst_req = 1'b1; step(100);
    chk("held_busy", 32'(busy), 32'h0);
    chk("held_one_ack", 32'(ack_cnt - a0), 32'd1);
    sw_rst_req = 1'b0; step(2);
    sw_rst_req = 1'b1; step(1);
    sw_rst_req = 1'b0;
    chk("rearm_busy", 32'(busy), 32'h1);
    step(30);
    chk("rearm_two_ack", 32'(ack_cnt - a0), 32'd2);

    // drain with one partition stuck busy
    a0 = ack_cnt;
    part_idle = 4'h7;
    sw_rst_req = 1'b1; step(1);
    sw_rst_req = 1'b0;
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
    step(255);
    chk("to_e255_terr", 32'(timeout_err), 32'h0);
    chk("to_e255_rst", 32'(part_rst), 32'h0);
    step(1);
    chk("to_e256_terr", 32'(timeout_err), 32'h1);
    chk("to_e256_rst", 32'(part_rst), 32'hF);
    part_idle = 4'hF;
    step(29);
    chk("to_done_busy", 32'(busy), 32'h0);
    chk("to_sticky", 32'(timeout_err), 32'h1);
`else
    step(300);
    chk("nto_busy", 32'(busy), 32'h1);
    chk("nto_terr", 32'(timeout_err), 32'h0);
    chk("nto_rst", 32'(part_rst), 32'h0);
    part_idle = 4'hF;
    step(1);  chk("nto_hold", 32'(part_rst), 32'hF);
    step(29); chk("nto_done_busy", 32'(busy), 32'h0);
`endif
    chk("drain_one_ack", 32'(ack_cnt - a0), 32'd1);

    // dla_reset pulsed while partition 2 has just been released
    a0 = ack_cnt;
    sw_rst_req = 1'b1; step(1);
    sw_rst_req = 1'b0;
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
    chk("to_clear_on_req", 32'(timeout_err), 32'h0);
`endif
    step(1);  step(25);
    chk("mid_rel_idx2", 32'(part_rst), 32'h8);
    dla_reset = 1'b1; step(1);
    chk("mid_rst_part", 32'(part_rst), 32'hF);
    chk("mid_rst_busy", 32'(busy), 32'h1);
    dla_reset = 1'b0;
    step(16); chk("mid_restart_e16", 32'(part_rst), 32'hE);
    step(13); chk("mid_done_busy", 32'(busy), 32'h0);
    chk("mid_no_ack", 32'(ack_cnt - a0), 32'd0);

    // DFT bypass: part_rst follows dla_reset every cycle
    test_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dla_reset = ((i % 3) != 0);
      #1;
      chk("tm_mirror", 32'(part_rst), dla_reset ? 32'hF : 32'h0);
    end
    test_mode = 1'b0;
    dla_reset = 1'b0;
    step(SEQ_END + 1);
    chk("tm_exit_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
